// File: rtl/cas_prefetch_fifo.sv
// rtl/cas_prefetch_fifo.sv - SDRAM-to-CAS-serializer prefetch buffer
// Fetches image bytes during CPU refresh slots into a small FWFT FIFO.
module cas_prefetch_fifo #(
   parameter int DEPTH_LOG2 = 3,
   parameter int ADDR_W     = 21,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rewind,
   input  logic [ADDR_W-1:0]     cas_size,
   input  logic                  sdram_available,
   output logic                  sdram_rd,
   output logic [ADDR_W-1:0]     sdram_addr,
   input  logic [7:0]            sdram_data,
   input  logic                  sdram_ready,
   input  logic                  byte_rd,
   output logic [7:0]            byte_out,
   output logic                  byte_valid,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  eof,
   output logic                  fetch_err
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam logic [DEPTH_LOG2+1:0] FULL  = (DEPTH_LOG2+2)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   ONE_L = (DEPTH_LOG2+1)'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

   state_t                  state, state_nx;
   logic [ADDR_W-1:0]       fetch_addr;
   logic [TW-1:0]           timer;
   logic [7:0]              mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
   logic                    push, pop, start, err_set, timed_out, inflight;
   logic [DEPTH_LOG2+1:0]   occupancy;

   // A request still in ISSUE/WAIT owns a FIFO slot; a drained one does not.
   assign inflight   = (state == ISSUE) || (state == WAIT);
   assign occupancy  = {1'b0, level} + (DEPTH_LOG2+2)'(inflight);
   assign timed_out  = (timer == TW'(TIMEOUT - 1)) && !sdram_ready;
   assign pop        = byte_rd && byte_valid && !rewind;
   assign byte_valid = (level != '0);
   assign byte_out   = byte_valid ? mem[rd_ptr] : 8'h00;
   assign sdram_rd   = (state != IDLE);

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      push     = 1'b0;
      err_set  = 1'b0;
      case (state)
         IDLE: begin
            if ((fetch_addr < cas_size) && (occupancy < FULL) &&
                sdram_available && !rewind) begin
               state_nx = ISSUE;
               start    = 1'b1;
            end
         end
         ISSUE: state_nx = rewind ? DRAIN : WAIT;
         WAIT: begin
            if (sdram_ready) begin
               push     = !rewind;
               state_nx = IDLE;
            end else if (timed_out) begin
               err_set  = 1'b1;
               state_nx = IDLE;
            end else if (rewind) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (sdram_ready) begin
               state_nx = IDLE;
            end else if (timed_out) begin
               err_set  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         timer      <= '0;
         sdram_addr <= '0;
         fetch_addr <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         eof        <= 1'b0;
         fetch_err  <= 1'b0;
      end else begin
         state <= state_nx;
         // Timer runs across WAIT->DRAIN so a drained request keeps its deadline.
         if (state == WAIT || state == DRAIN)
            timer <= timer + TW'(1);
         else
            timer <= '0;
         if (start)
            sdram_addr <= fetch_addr;
         if (err_set)
            fetch_err <= 1'b1;
         if (rewind) begin
            fetch_addr <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            eof        <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr     <= wr_ptr + DEPTH_LOG2'(1);
               fetch_addr <= fetch_addr + ADDR_W'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
               2'b10:   level <= level + ONE_L;
               2'b01:   level <= level - ONE_L;
               default: level <= level;
            endcase
            eof <= (fetch_addr == cas_size) && (level == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= sdram_data;
   end

endmodule
